// File: rtl/sdram_device_model.sv
// sdram_device_model: cycle-accurate x8 SDR SDRAM responder with bank tracking, CAS-latency read pipe and error flags
module sdram_device_model #(
  parameter int ROW_WIDTH      = 13,
  parameter int COL_WIDTH      = 10,
  parameter int BANK_WIDTH     = 2,
  parameter int SDRADDR_WIDTH  = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int TRCD           = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clock_enable,
  input  logic                     cs_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     we_n,
  input  logic [SDRADDR_WIDTH-1:0] addr,
  input  logic [BANK_WIDTH-1:0]    bank_addr,
  input  logic                     data_mask,
  input  logic [7:0]               dq_in,
  output logic [7:0]               dq_out,
  output logic                     dq_oe,
  output logic                     init_done,
  output logic                     proto_err,
  output logic                     timing_err,
  output logic [15:0]              refresh_count
);
  localparam int NB = 1 << BANK_WIDTH;
  localparam int CW = (TRCD > 1) ? $clog2(TRCD) : 1;
  localparam int FW = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
  logic [NB-1:0]        open_b;
  logic [ROW_WIDTH-1:0] row_r [NB];
  logic [CW-1:0]        trcd_r [NB];
  logic [7:0]           mem [2**MEM_ADDR_WIDTH];
  logic [1:0]           cl;
  logic                 d1_v, d2_v;
  logic [7:0]           d1_d, d2_d;
  logic [3:0]           cmd;
  logic                 sel, act, rd, wr, pre, rfr, mrs, bst;
  logic                 bopen, rw_ok, all_closed, cl_ok, perr, terr, do_wr, out_v;
  logic [2:0]           mode_cl;
  logic [FW-1:0]        idx_full;
  logic [MEM_ADDR_WIDTH-1:0] idx;
  logic [7:0]           out_d;
  always_comb begin
    cmd        = {cs_n, ras_n, cas_n, we_n};
    sel        = clock_enable && !cs_n;
    act        = sel && cmd[2:0] == 3'b011;
    rd         = sel && cmd[2:0] == 3'b101;
    wr         = sel && cmd[2:0] == 3'b100;
    pre        = sel && cmd[2:0] == 3'b010;
    rfr        = sel && cmd[2:0] == 3'b001;
    mrs        = sel && cmd[2:0] == 3'b000;
    bst        = sel && cmd[2:0] == 3'b110;
    bopen      = open_b[bank_addr];
    rw_ok      = init_done && bopen;
    all_closed = ~|open_b;
    mode_cl    = addr[6:4];
    cl_ok      = mode_cl == 3'd2 || mode_cl == 3'd3;
    idx_full   = {bank_addr, row_r[bank_addr], addr[COL_WIDTH-1:0]};
    idx        = idx_full[MEM_ADDR_WIDTH-1:0];
    do_wr      = wr && rw_ok && !data_mask;
    perr       = bst || (act && bopen) || (rd && !rw_ok) || (wr && (!rw_ok || dq_oe)) ||
                 (rfr && !all_closed) || (mrs && (!all_closed || !cl_ok || addr[2:0] != 3'd0));
    terr       = (rd || wr) && rw_ok && trcd_r[bank_addr] != '0;
    out_v      = (cl == 2'd3) ? d2_v : d1_v;
    out_d      = (cl == 2'd3) ? d2_d : d1_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      open_b        <= '0;
      cl            <= 2'd2;
      init_done     <= 1'b0;
      proto_err     <= 1'b0;
      timing_err    <= 1'b0;
      refresh_count <= '0;
      d1_v          <= 1'b0;
      d2_v          <= 1'b0;
      dq_oe         <= 1'b0;
      dq_out        <= '0;
      for (int b = 0; b < NB; b++) trcd_r[b] <= '0;
    end else begin
      proto_err  <= perr;
      timing_err <= terr;
      for (int b = 0; b < NB; b++)
        if (clock_enable && trcd_r[b] != '0) trcd_r[b] <= trcd_r[b] - 1'b1;
      if (act && !bopen) begin
        open_b[bank_addr] <= 1'b1;
        row_r[bank_addr]  <= addr[ROW_WIDTH-1:0];
        trcd_r[bank_addr] <= CW'(TRCD - 1);
      end
      if (pre) begin
        if (addr[10]) open_b <= '0;
        else open_b[bank_addr] <= 1'b0;
      end
      if ((rd || wr) && rw_ok && addr[10]) open_b[bank_addr] <= 1'b0;
      if (rfr && all_closed) refresh_count <= refresh_count + 16'd1;
      if (mrs && all_closed && cl_ok) begin
        cl        <= mode_cl[1:0];
        init_done <= 1'b1;
      end
      d1_v   <= rd && rw_ok;
      d2_v   <= d1_v;
      dq_oe  <= out_v;
      dq_out <= out_v ? out_d : 8'd0;
    end
  end
  // Backing store is deliberately left out of reset so data survives re-init.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[idx] <= dq_in;
    d1_d <= mem[idx];
    d2_d <= d1_d;
  end
endmodule

// File: tb/tb_sdram_device_model.sv
// tb_sdram_device_model: scoreboard bench; expected read data and arrival cycle queued at READ, matched when dq_oe rises
module tb_sdram_device_model;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100,
                         PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  logic        clk = 0, rst = 1, clock_enable = 1;
  logic        cs_n = 0, ras_n = 1, cas_n = 1, we_n = 1;
  logic [12:0] addr = 0;
  logic [1:0]  bank_addr = 0;
  logic        data_mask = 0;
  logic [7:0]  dq_in = 0, dq_out;
  logic        dq_oe, init_done, proto_err, timing_err;
  logic [15:0] refresh_count;
  typedef struct { logic [7:0] d; int c; } exp_t;
  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0, cl_tb = 2;
  logic perr_seen = 0, terr_seen = 0;
  sdram_device_model dut (
    .clk(clk), .rst(rst), .clock_enable(clock_enable), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .addr(addr), .bank_addr(bank_addr), .data_mask(data_mask),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .init_done(init_done),
    .proto_err(proto_err), .timing_err(timing_err), .refresh_count(refresh_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (dq_oe) begin
      if (q.size() == 0) check("unexpected_oe", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("rd_data", dq_out, e.d);
        check("rd_cycle", cyc, e.c);
      end
    end
  end
  task automatic op(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                    input logic [7:0] d = 8'h00, input logic m = 1'b0);
    {cs_n, ras_n, cas_n, we_n} = c;
    bank_addr = b; addr = a; dq_in = d; data_mask = m;
    @(posedge clk); #1;
    perr_seen |= proto_err;
    terr_seen |= timing_err;
    {cs_n, ras_n, cas_n, we_n} = NOP;
  endtask
  task automatic nops(input int n);
    repeat (n) op(NOP, 0, 0);
  endtask
  task automatic rd(input logic [1:0] b, input logic [12:0] a, input logic [7:0] d, input logic push);
    op(RD, b, a);
    if (push) q.push_back('{d, cyc + cl_tb - 1});
  endtask
  task automatic mrs(input logic [12:0] a, input int cl);
    op(MRS, 0, a);
    cl_tb = cl;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_refresh", refresh_count, 0);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_dq_out", dq_out, 0);
    check("rst_perr", proto_err, 0);
    rst = 0;
    nops(4);
    op(PRE, 0, 13'h400);
    op(REF, 0, 0);
    op(REF, 0, 0);
    check("pre_init_done", init_done, 0);
    mrs(13'h220, 2);
    check("init_done", init_done, 1);
    check("refresh_2", refresh_count, 2);
    op(ACT, 1, 13'h005);
    nops(2);
    op(WR, 1, 13'h403, 8'hA5);
    op(ACT, 1, 13'h005);
    nops(2);
    rd(1, 13'h003, 8'hA5, 1);
    nops(3);
    check("cl2_clean_perr", perr_seen, 0);
    check("cl2_clean_terr", terr_seen, 0);
    op(PRE, 0, 13'h400);
    mrs(13'h230, 3);
    op(ACT, 1, 13'h005);
    nops(2);
    rd(1, 13'h003, 8'hA5, 1);
    nops(4);
    op(WR, 1, 13'h003, 8'h11, 1'b1);
    rd(1, 13'h403, 8'hA5, 1);
    nops(4);
    check("cl3_clean_perr", perr_seen, 0);
    op(ACT, 1, 13'h005);
    rd(1, 13'h403, 8'hA5, 1);
    check("trcd_terr", timing_err, 1);
    nops(4);
    check("trcd_terr_clears", timing_err, 0);
    rd(1, 13'h003, 8'h00, 0);
    check("rd_closed_perr", proto_err, 1);
    nops(4);
    op(ACT, 2, 13'h007);
    check("act_ok", proto_err, 0);
    op(ACT, 2, 13'h009);
    check("act_open_perr", proto_err, 1);
    op(REF, 0, 0);
    check("ref_open_perr", proto_err, 1);
    check("ref_open_count", refresh_count, 2);
    op(PRE, 0, 13'h400);
    mrs(13'h220, 2);
    op(ACT, 1, 13'h005);
    nops(2);
    rd(1, 13'h003, 8'h00, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("midrd_rst_oe", dq_oe, 0);
    check("midrd_rst_init", init_done, 0);
    nops(4);
    cl_tb = 2;
    op(PRE, 0, 13'h400);
    mrs(13'h220, 2);
    check("reinit_done", init_done, 1);
    op(ACT, 1, 13'h005);
    nops(2);
    rd(1, 13'h003, 8'hA5, 1);
    for (int i = 0; i < 20 && q.size() != 0; i++) nops(1);
    nops(2);
    check("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
